perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_counter_bank_pkg.sv | 16 +
 rtl/perf_counter_bank_cell.sv | 68 ++++++
 rtl/perf_counter_bank.sv | 84 ++++++++
 tb/tb_perf_counter_bank.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/perf_counter_bank_pkg.sv
// Shared constants for the performance counter bank.
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter
//   CNT_BITS_DEFAULT     : default counter width
//   wrap_inc()           : modulo-N increment used for the channel selector
package perf_counter_bank_pkg;

    localparam int unsigned MODE_WRAP        = 0;
    localparam int unsigned MODE_SAT         = 1;
    localparam int unsigned CNT_BITS_DEFAULT = 32;

    // Increment an index and wrap at n, so n need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/perf_counter_bank_cell.sv
// Single-channel event counter with shadow copy and sticky overflow flag.
// Ports:
//   clk, rst     : clock, async active-high reset
//   inc_i        : count request this cycle (global enable AND channel event)
//   clr_i        : synchronous clear of live count and overflow flag
//   snap_i       : copy the current live count into the shadow register
//   live_o       : live count
//   shadow_o     : shadow count
//   ovf_o        : sticky overflow flag
module perf_counter_cell
    import perf_counter_bank_pkg::*;
#(
    parameter int unsigned CNT_BITS = CNT_BITS_DEFAULT,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc_i,
    input  logic                clr_i,
    input  logic                snap_i,
    output logic [CNT_BITS-1:0] live_o,
    output logic [CNT_BITS-1:0] shadow_o,
    output logic                ovf_o
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [CNT_BITS-1:0] live_q, live_d;
    logic [CNT_BITS-1:0] shadow_q, shadow_d;
    logic                ovf_q, ovf_d;

    always_comb begin
        live_d   = live_q;
        ovf_d    = ovf_q;
        // Shadow takes the pre-edge live value, so a same-cycle increment
        // or clear is never visible in the snapshot.
        shadow_d = snap_i ? live_q : shadow_q;

        if (clr_i) begin
            live_d = '0;
            ovf_d  = 1'b0;
        end else if (inc_i) begin
            if (live_q == CNT_MAX) begin
                ovf_d  = 1'b1;
                live_d = (SATURATE == MODE_SAT) ? CNT_MAX : '0;
            end else begin
                live_d = live_q + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q   <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign live_o   = live_q;
    assign shadow_o = shadow_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with a button-driven display selector.
// Ports:
//   clk, rst   : clock, async active-high reset
//   en         : global count enable
//   evt        : per-channel event qualifiers
//   clr        : synchronous clear of all live counters and overflow flags
//   snap       : copy all live counters into their shadows
//   next_btn   : synchronised button level; each rising edge advances sel
//   view_live  : 1 shows live[sel], 0 shows shadow[sel]
//   data_out   : selected channel value (combinational from registers)
//   sel_out    : currently selected channel
//   ovf        : sticky per-channel overflow flags
module perf_counter_bank
    import perf_counter_bank_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_BITS = CNT_BITS_DEFAULT,
    parameter int unsigned SATURATE = MODE_WRAP,
    localparam int unsigned SEL_W   = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_CH-1:0]   evt,
    input  logic                clr,
    input  logic                snap,
    input  logic                next_btn,
    input  logic                view_live,
    output logic [CNT_BITS-1:0] data_out,
    output logic [SEL_W-1:0]    sel_out,
    output logic [NUM_CH-1:0]   ovf
);

    logic [NUM_CH-1:0][CNT_BITS-1:0] live;
    logic [NUM_CH-1:0][CNT_BITS-1:0] shadow;

    logic             btn_q;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             btn_rise;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cell
            perf_counter_cell #(
                .CNT_BITS (CNT_BITS),
                .SATURATE (SATURATE)
            ) u_cell (
                .clk      (clk),
                .rst      (rst),
                .inc_i    (en & evt[gi]),
                .clr_i    (clr),
                .snap_i   (snap),
                .live_o   (live[gi]),
                .shadow_o (shadow[gi]),
                .ovf_o    (ovf[gi])
            );
        end
    endgenerate

    // btn_q resets low, so a button already held through reset release
    // counts as one press on the first cycle after reset.
    assign btn_rise = next_btn & ~btn_q;

    always_comb begin
        sel_d = sel_q;
        if (btn_rise) begin
            sel_d = SEL_W'(wrap_inc(32'(sel_q), NUM_CH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= 1'b0;
            sel_q <= '0;
        end else begin
            btn_q <= next_btn;
            sel_q <= sel_d;
        end
    end

    assign sel_out  = sel_q;
    assign data_out = view_live ? live[sel_q] : shadow[sel_q];

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;
    import perf_counter_bank_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, clr, snap, next_btn, view_live;
    logic [3:0] evt;

    logic [3:0]  dout_a, dout_b;
    logic [31:0] dout_c;
    logic [1:0]  sel_a, sel_b, sel_c;
    logic [3:0]  ovf_a, ovf_b;
    logic [2:0]  ovf_c;

    always #5 clk = ~clk;

    // a: 4-bit wrap, b: 4-bit saturate, c: 3 channels, default width
    perf_counter_bank #(.NUM_CH(4), .CNT_BITS(4), .SATURATE(MODE_WRAP)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .evt(evt), .clr(clr), .snap(snap),
        .next_btn(next_btn), .view_live(view_live),
        .data_out(dout_a), .sel_out(sel_a), .ovf(ovf_a));
    perf_counter_bank #(.NUM_CH(4), .CNT_BITS(4), .SATURATE(MODE_SAT)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .evt(evt), .clr(clr), .snap(snap),
        .next_btn(next_btn), .view_live(view_live),
        .data_out(dout_b), .sel_out(sel_b), .ovf(ovf_b));
    perf_counter_bank #(.NUM_CH(3)) u_dut_c (
        .clk(clk), .rst(rst), .en(en), .evt(evt[2:0]), .clr(clr), .snap(snap),
        .next_btn(next_btn), .view_live(view_live),
        .data_out(dout_c), .sel_out(sel_c), .ovf(ovf_c));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: each channel keeps the true number of events since
    // the last clear; the visible value and overflow follow from that total.
    int    NCH  [3] = '{4, 4, 3};
    int    WB   [3] = '{4, 4, 32};
    int    SATM [3] = '{MODE_WRAP, MODE_SAT, MODE_WRAP};
    longint tot [3][4];
    longint shd [3][4];
    int    msel [3];
    bit    btn_prev;

    function automatic longint cmax(input int d);
        return (longint'(1) << WB[d]) - 1;
    endfunction

    function automatic longint mval(input int d, input longint t);
        if (SATM[d] == MODE_SAT) return (t > cmax(d)) ? cmax(d) : t;
        return t % (cmax(d) + 1);
    endfunction

    function automatic logic [63:0] exp_ovf(input int d);
        logic [63:0] v = '0;
        for (int ch = 0; ch < NCH[d]; ch++) v[ch] = (tot[d][ch] > cmax(d));
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            msel[d] = 0;
            for (int ch = 0; ch < 4; ch++) begin
                tot[d][ch] = 0;
                shd[d][ch] = 0;
            end
        end
        btn_prev = 1'b0;
    endtask

    task automatic model_step();
        bit rise = next_btn && !btn_prev;
        btn_prev = next_btn;
        for (int d = 0; d < 3; d++) begin
            for (int ch = 0; ch < NCH[d]; ch++) begin
                if (snap) shd[d][ch] = mval(d, tot[d][ch]);
                if (clr) tot[d][ch] = 0;
                else if (en && evt[ch]) tot[d][ch]++;
            end
            if (rise) msel[d] = (msel[d] + 1) % NCH[d];
        end
    endtask

    task automatic check_all();
        #1;
        chk("sel_a", sel_a, msel[0]);
        chk("sel_b", sel_b, msel[1]);
        chk("sel_c", sel_c, msel[2]);
        chk("ovf_a", ovf_a, exp_ovf(0));
        chk("ovf_b", ovf_b, exp_ovf(1));
        chk("ovf_c", ovf_c, exp_ovf(2));
        view_live = 1'b1;
        #1;
        chk("live_a", dout_a, mval(0, tot[0][msel[0]]));
        chk("live_b", dout_b, mval(1, tot[1][msel[1]]));
        chk("live_c", dout_c, mval(2, tot[2][msel[2]]));
        view_live = 1'b0;
        #1;
        chk("shadow_a", dout_a, shd[0][msel[0]]);
        chk("shadow_b", dout_b, shd[1][msel[1]]);
        chk("shadow_c", dout_c, shd[2][msel[2]]);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        check_all();
    endtask

    task automatic press();
        next_btn = 1'b1;
        cyc();
        next_btn = 1'b0;
        cyc();
    endtask

    int seq5 [3] = '{2, 0, 1};

    initial begin
        rst = 1'b1; en = 1'b0; evt = '0; clr = 1'b0; snap = 1'b0;
        next_btn = 1'b0; view_live = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        check_all();
        rst = 1'b0;

        // Scenario 1: ten events on channel 0, then idle
        en = 1'b1; evt = 4'b0001;
        repeat (10) cyc();
        evt = '0;
        repeat (5) cyc();
        view_live = 1'b1; #1;
        chk("s1_live0", dout_c, 10);
        chk("s1_ovf", ovf_c, 0);

        // Scenario 2: 17 events on channel 1, wrap vs saturate
        clr = 1'b1; cyc(); clr = 1'b0;
        press();
        evt = 4'b0010;
        repeat (17) cyc();
        evt = '0; cyc();
        view_live = 1'b1; #1;
        chk("s2_wrap_live", dout_a, 1);
        chk("s2_sat_live", dout_b, 15);
        chk("s2_wrap_ovf", ovf_a, 4'b0010);
        chk("s2_sat_ovf", ovf_b, 4'b0010);

        // Scenario 3: snap excludes the same-cycle event
        clr = 1'b1; cyc(); clr = 1'b0;
        press();
        evt = 4'b0100;
        repeat (7) cyc();
        snap = 1'b1; cyc(); snap = 1'b0; evt = '0;
        view_live = 1'b0; #1;
        chk("s3_shadow", dout_a, 7);
        view_live = 1'b1; #1;
        chk("s3_live", dout_a, 8);

        // Scenario 4: snap together with clr (channel 0 on the 3-ch bank)
        press();
        clr = 1'b1; cyc(); clr = 1'b0;
        evt = 4'b0001;
        repeat (20) cyc();
        evt = '0; snap = 1'b1; clr = 1'b1;
        cyc();
        snap = 1'b0; clr = 1'b0;
        view_live = 1'b0; #1;
        chk("s4_shadow", dout_c, 20);
        view_live = 1'b1; #1;
        chk("s4_live", dout_c, 0);
        chk("s4_ovf_a", ovf_a, 0);

        // Scenario 5: held button advances once, then three single presses
        next_btn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("s5_hold", sel_c, 1);
        end
        next_btn = 1'b0; cyc();
        for (int p = 0; p < 3; p++) begin
            press();
            chk("s5_pulse", sel_c, seq5[p]);
        end

        // Scenario 6: reset between edges, button held through release
        en = 1'b1; evt = 4'hF;
        repeat (3) cyc();
        rst = 1'b1; next_btn = 1'b1;
        model_reset();
        #1;
        chk("s6_sel", sel_c, 0);
        chk("s6_ovf", ovf_a, 0);
        view_live = 1'b1; #1;
        chk("s6_live", dout_c, 0);
        view_live = 1'b0; #1;
        chk("s6_shadow", dout_c, 0);
        rst = 1'b0;
        cyc();
        view_live = 1'b1; #1;
        chk("s6_restart", dout_c, 1);
        next_btn = 1'b0;

        // Randomised traffic against the model
        repeat (400) begin
            en       = ($urandom_range(0, 3) != 0);
            evt      = 4'($urandom);
            clr      = ($urandom_range(0, 19) == 0);
            snap     = ($urandom_range(0, 7) == 0);
            next_btn = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
